// File: rtl/dsp_pkg.sv
// ============================================================================
// Module  : dsp_pkg
// Purpose : Shared widths, OPMODE field positions, mux selects, saturation limits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_pkg;

    localparam int DSP_MW = 36;
    localparam int DSP_PW = 48;

    localparam int OPM_X_LSB = 0;
    localparam int OPM_Z_LSB = 2;
    localparam int OPM_SEL_W = 2;
    localparam int OPM_CIN   = 4;
    localparam int OPM_SUB   = 5;

    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

    localparam logic [DSP_PW-1:0] SAT_POS = {1'b0, {(DSP_PW-1){1'b1}}};
    localparam logic [DSP_PW-1:0] SAT_NEG = {1'b1, {(DSP_PW-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/dsp_ce_reg.sv
// ============================================================================
// Module  : dsp_ce_reg
// Purpose : W-bit register with async active-high reset, CE hold and bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_ce_reg #(
    parameter int W   = 1,
    parameter int REG = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (REG != 0) begin : g_reg
            logic [W-1:0] r_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_q <= '0;
                end else if (ce) begin
                    r_q <= d;
                end
            end

            assign q = r_q;
        end else begin : g_bypass
            assign q = d;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dsp_post_accum.sv
// ============================================================================
// Module  : dsp_post_accum
// Purpose : DSP post-adder / accumulator with OPMODE, P and CARRYOUT registers.
//           Optional saturation enabled by defining DSP_POSTADD_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_post_accum
    import dsp_pkg::*;
#(
    parameter int OPMODEREG   = 1,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter int MW          = DSP_MW,
    parameter int PW          = DSP_PW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CEOPMODE,
    input  logic          CEP,
    input  logic          CECARRYOUT,
    input  logic [5:0]    OPMODE,
    input  logic [MW-1:0] M,
    input  logic [PW-1:0] DAB,
    input  logic [PW-1:0] C,
    input  logic [PW-1:0] PCIN,
    input  logic          CARRYIN,
    output logic [PW-1:0] P,
    output logic [PW-1:0] PCOUT,
    output logic          CARRYOUT,
    output logic          OVF
);

    logic [5:0]    w_opm;
    logic [PW-1:0] w_x;
    logic [PW-1:0] w_z;
    logic          w_cin;
    logic          w_sub;
    logic [PW-1:0] w_result;
    logic          w_carry;
    logic [PW-1:0] r_p;

    dsp_ce_reg #(.W(6), .REG(OPMODEREG)) u_opmode_reg (
        .CLK (CLK),
        .RST (RST),
        .ce  (CEOPMODE),
        .d   (OPMODE),
        .q   (w_opm)
    );

    // Feedback selects always tap r_p so PREG=0 cannot form a combinational loop.
    always_comb begin
        w_x = '0;
        case (w_opm[OPM_X_LSB +: OPM_SEL_W])
            X_ZERO:  w_x = '0;
            X_M:     w_x = {{(PW-MW){M[MW-1]}}, M};
            X_P:     w_x = r_p;
            default: w_x = DAB;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (w_opm[OPM_Z_LSB +: OPM_SEL_W])
            Z_ZERO:  w_z = '0;
            Z_PCIN:  w_z = PCIN;
            Z_P:     w_z = r_p;
            default: w_z = C;
        endcase
    end

    assign w_cin = w_opm[OPM_CIN] ? 1'b1 : CARRYIN;
    assign w_sub = w_opm[OPM_SUB];

`ifdef DSP_POSTADD_SAT_EN
    logic [PW+1:0] w_ssum;
    logic          w_ovf;

    always_comb begin
        w_ssum = '0;
        if (w_sub) begin
            w_ssum = {{2{w_z[PW-1]}}, w_z}
                   - ({{2{w_x[PW-1]}}, w_x} + {{(PW+1){1'b0}}, w_cin});
        end else begin
            w_ssum = {{2{w_z[PW-1]}}, w_z} + {{2{w_x[PW-1]}}, w_x}
                   + {{(PW+1){1'b0}}, w_cin};
        end
    end

    // Sign extension shifts bit PW by (z_sign ^ x_sign) relative to the unsigned sum.
    assign w_carry  = w_ssum[PW] ^ w_z[PW-1] ^ w_x[PW-1];
    assign w_ovf    = !((w_ssum[PW+1] == w_ssum[PW]) && (w_ssum[PW] == w_ssum[PW-1]));
    assign w_result = w_ovf ? (w_ssum[PW+1] ? PW'(SAT_NEG) : PW'(SAT_POS))
                            : w_ssum[PW-1:0];

    dsp_ce_reg #(.W(1), .REG(PREG)) u_ovf_reg (
        .CLK (CLK),
        .RST (RST),
        .ce  (CEP),
        .d   (w_ovf),
        .q   (OVF)
    );
`else
    logic [PW:0] w_sum;

    always_comb begin
        w_sum = '0;
        if (w_sub) begin
            w_sum = {1'b0, w_z} - ({1'b0, w_x} + {{PW{1'b0}}, w_cin});
        end else begin
            w_sum = {1'b0, w_z} + {1'b0, w_x} + {{PW{1'b0}}, w_cin};
        end
    end

    assign w_carry  = w_sum[PW];
    assign w_result = w_sum[PW-1:0];
    assign OVF      = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_p <= '0;
        end else if (CEP) begin
            r_p <= w_result;
        end
    end

    generate
        if (PREG != 0) begin : g_preg
            assign P = r_p;
        end else begin : g_preg_bypass
            assign P = w_result;
        end
    endgenerate

    assign PCOUT = P;

    dsp_ce_reg #(.W(1), .REG(CARRYOUTREG)) u_carry_reg (
        .CLK (CLK),
        .RST (RST),
        .ce  (CECARRYOUT),
        .d   (w_carry),
        .q   (CARRYOUT)
    );

endmodule

`default_nettype wire

// File: tb/tb_dsp_post_accum.sv
// ============================================================================
// Module  : tb_dsp_post_accum
// Purpose : Directed self-checking bench; fully registered DUT plus a
//           fully combinational instance sharing the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_post_accum;

    logic        CLK;
    logic        RST;
    logic        CEOPMODE;
    logic        CEP;
    logic        CECARRYOUT;
    logic [5:0]  OPMODE;
    logic [35:0] M;
    logic [47:0] DAB;
    logic [47:0] C;
    logic [47:0] PCIN;
    logic        CARRYIN;

    logic [47:0] P, PCOUT, P_c, PCOUT_c;
    logic        CARRYOUT, OVF, CARRYOUT_c, OVF_c;

    int n_tests = 0;
    int n_fail  = 0;

    dsp_post_accum #(.OPMODEREG(1), .PREG(1), .CARRYOUTREG(1)) dut (
        .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CEP(CEP), .CECARRYOUT(CECARRYOUT),
        .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .OVF(OVF)
    );

    dsp_post_accum #(.OPMODEREG(0), .PREG(0), .CARRYOUTREG(0)) dut_c (
        .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CEP(CEP), .CECARRYOUT(CECARRYOUT),
        .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .P(P_c), .PCOUT(PCOUT_c), .CARRYOUT(CARRYOUT_c), .OVF(OVF_c)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        OPMODE = 6'b001101; C = 48'h123; M = 36'd7; DAB = 48'h55; PCIN = 48'h66; CARRYIN = 1'b1;
        CEOPMODE = 1'b1; CEP = 1'b1; CECARRYOUT = 1'b1;
        step();
        step();
        n_tests++; if (P !== 48'h12B) begin n_fail++; $display("FAIL pre_reset_p: got %h want %h", P, 48'h12B); end
        #3 RST = 1'b1;
        #1;
        n_tests++; if (P !== 48'd0) begin n_fail++; $display("FAIL rst_p: got %h want 0", P); end
        n_tests++; if (PCOUT !== 48'd0) begin n_fail++; $display("FAIL rst_pcout: got %h want 0", PCOUT); end
        n_tests++; if (CARRYOUT !== 1'b0 || OVF !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got co=%b ovf=%b want 0 0", CARRYOUT, OVF); end
        step();
        CEOPMODE = 1'b0; CEP = 1'b0; CECARRYOUT = 1'b0;
        RST = 1'b0;
        step();
        n_tests++; if (P !== 48'd0) begin n_fail++; $display("FAIL post_rst_hold: got %h want 0", P); end
    endtask

    task automatic test_accumulate();
        OPMODE = 6'b001001; M = 36'd5; CARRYIN = 1'b0; CEOPMODE = 1'b1;
        step();
        n_tests++; if (P_c !== 48'd5) begin n_fail++; $display("FAIL acc_comb0: got %h want %h", P_c, 48'd5); end
        CEP = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_tests++; if (P !== 48'(5 * i)) begin n_fail++; $display("FAIL acc_%0d: got %h want %h", i, P, 48'(5 * i)); end
        end
        n_tests++; if (PCOUT !== 48'd20) begin n_fail++; $display("FAIL acc_pcout: got %h want %h", PCOUT, 48'd20); end
        CEP = 1'b0;
        step();
        step();
        n_tests++; if (P !== 48'd20) begin n_fail++; $display("FAIL acc_hold: got %h want %h", P, 48'd20); end
        n_tests++; if (P_c !== 48'd25) begin n_fail++; $display("FAIL acc_comb_hold: got %h want %h", P_c, 48'd25); end
        M = 36'hF_FFFF_FFFD;
        CEP = 1'b1;
        step();
        CEP = 1'b0;
        n_tests++; if (P !== 48'd17) begin n_fail++; $display("FAIL acc_neg: got %h want %h", P, 48'd17); end
        n_tests++; if (P_c !== 48'd14) begin n_fail++; $display("FAIL acc_neg_comb: got %h want %h", P_c, 48'd14); end
    endtask

    task automatic test_subtract();
        OPMODE = 6'b101111; C = 48'd3; DAB = 48'd5; CARRYIN = 1'b0;
        CEOPMODE = 1'b1; CEP = 1'b0; CECARRYOUT = 1'b0;
        #1;
        n_tests++; if (P_c !== 48'hFFFF_FFFF_FFFE || CARRYOUT_c !== 1'b1) begin n_fail++; $display("FAIL sub_comb: got %h co=%b want fffffffffffe co=1", P_c, CARRYOUT_c); end
        step();
        CEP = 1'b1; CECARRYOUT = 1'b1;
        step();
        CEP = 1'b0; CECARRYOUT = 1'b0;
        n_tests++; if (P !== 48'hFFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_p: got %h want fffffffffffe", P); end
        n_tests++; if (CARRYOUT !== 1'b1 || OVF !== 1'b0) begin n_fail++; $display("FAIL sub_flags: got co=%b ovf=%b want 1 0", CARRYOUT, OVF); end
    endtask

    task automatic test_wrap();
        OPMODE = 6'b011100; C = 48'hFFFF_FFFF_FFFF; CARRYIN = 1'b0;
        #1;
        n_tests++; if (P_c !== 48'd0 || CARRYOUT_c !== 1'b1 || OVF_c !== 1'b0) begin n_fail++; $display("FAIL wrap_comb: got %h co=%b ovf=%b want 0 1 0", P_c, CARRYOUT_c, OVF_c); end
        step();
        CEP = 1'b1; CECARRYOUT = 1'b1;
        step();
        CEP = 1'b0; CECARRYOUT = 1'b0;
        n_tests++; if (P !== 48'd0) begin n_fail++; $display("FAIL wrap_p: got %h want 0", P); end
        n_tests++; if (CARRYOUT !== 1'b1 || OVF !== 1'b0) begin n_fail++; $display("FAIL wrap_flags: got co=%b ovf=%b want 1 0", CARRYOUT, OVF); end
    endtask

    task automatic test_opmode_reg();
        C = 48'd10; DAB = 48'd4; CARRYIN = 1'b0;
        OPMODE = 6'b001111; CEOPMODE = 1'b1; CEP = 1'b1; CECARRYOUT = 1'b1;
        step();
        n_tests++; if (P !== 48'd11) begin n_fail++; $display("FAIL opm_old: got %h want %h", P, 48'd11); end
        step();
        n_tests++; if (P !== 48'd14) begin n_fail++; $display("FAIL opm_add: got %h want %h", P, 48'd14); end
        OPMODE = 6'b101111;
        #1;
        n_tests++; if (P_c !== 48'd6) begin n_fail++; $display("FAIL opm_comb_sub: got %h want %h", P_c, 48'd6); end
        step();
        n_tests++; if (P !== 48'd14) begin n_fail++; $display("FAIL opm_edge1: got %h want %h", P, 48'd14); end
        step();
        n_tests++; if (P !== 48'd6 || CARRYOUT !== 1'b0) begin n_fail++; $display("FAIL opm_edge2: got %h co=%b want 6 co=0", P, CARRYOUT); end
        CEOPMODE = 1'b0; OPMODE = 6'b001111;
        step();
        step();
        n_tests++; if (P !== 48'd6) begin n_fail++; $display("FAIL opm_ce_hold: got %h want %h", P, 48'd6); end
        n_tests++; if (P_c !== 48'd14) begin n_fail++; $display("FAIL opm_comb_add: got %h want %h", P_c, 48'd14); end
        CEP = 1'b0; CECARRYOUT = 1'b0;
    endtask

    task automatic test_saturation();
        logic [47:0] exp_pos, exp_neg;
        logic        exp_ovf;
`ifdef DSP_POSTADD_SAT_EN
        exp_pos = 48'h7FFF_FFFF_FFFF; exp_neg = 48'h8000_0000_0000; exp_ovf = 1'b1;
`else
        exp_pos = 48'h8000_0000_0000; exp_neg = 48'h7FFF_FFFF_FFFF; exp_ovf = 1'b0;
`endif
        OPMODE = 6'b001101; C = 48'h7FFF_FFFF_FFFF; M = 36'd1; CARRYIN = 1'b0; CEOPMODE = 1'b1;
        #1;
        n_tests++; if (P_c !== exp_pos || OVF_c !== exp_ovf) begin n_fail++; $display("FAIL sat_pos_comb: got %h ovf=%b want %h ovf=%b", P_c, OVF_c, exp_pos, exp_ovf); end
        step();
        CEP = 1'b1; CECARRYOUT = 1'b1;
        step();
        n_tests++; if (P !== exp_pos || OVF !== exp_ovf) begin n_fail++; $display("FAIL sat_pos: got %h ovf=%b want %h ovf=%b", P, OVF, exp_pos, exp_ovf); end
        n_tests++; if (CARRYOUT !== 1'b0) begin n_fail++; $display("FAIL sat_pos_co: got %b want 0", CARRYOUT); end
        OPMODE = 6'b101101; C = 48'h8000_0000_0000;
        step();
        step();
        n_tests++; if (P !== exp_neg || OVF !== exp_ovf) begin n_fail++; $display("FAIL sat_neg: got %h ovf=%b want %h ovf=%b", P, OVF, exp_neg, exp_ovf); end
        OPMODE = 6'b001101; C = 48'd5;
        step();
        step();
        n_tests++; if (P !== 48'd6 || OVF !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %h ovf=%b want 6 ovf=0", P, OVF); end
        CEP = 1'b0; CECARRYOUT = 1'b0; CEOPMODE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; CEOPMODE = 1'b0; CEP = 1'b0; CECARRYOUT = 1'b0;
        OPMODE = '0; M = '0; DAB = '0; C = '0; PCIN = '0; CARRYIN = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();
        test_reset();
        test_accumulate();
        test_subtract();
        test_wrap();
        test_opmode_reg();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dsp_post_accum.md
Name: dsp_post_accum

Overview:
- Post-adder/accumulator stage of the Spartan-6 style DSP slice model.
- Sits directly downstream of the multiplier's M register/bypass stage. Consumes the 36-bit signed product plus the C, D:A:B and PCIN operands.
- Produces the 48-bit P result, the PCOUT cascade and the carry-out.
- Contains the OPMODE register, the X/Z operand muxes, the add/subtract unit, the P accumulator register and the CARRYOUT register.

Parameters:
- OPMODEREG, 1, 1 = OPMODE registered (enabled by CEOPMODE); 0 = OPMODE used combinationally.
- PREG, 1, 1 = P/PCOUT driven from the P register; 0 = P/PCOUT driven from the adder result combinationally.
- CARRYOUTREG, 1, 1 = CARRYOUT registered (enabled by CECARRYOUT); 0 = combinational.
- MW, 36, product width.
- PW, 48, result width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high; clears every register in the block.
- CEOPMODE  in  1  clock enable, OPMODE register.
- CEP  in  1  clock enable, P register.
- CECARRYOUT  in  1  clock enable, CARRYOUT register.
- OPMODE  in  6  [1:0] X sel, [3:2] Z sel, [4] CIN sel, [5] SUB.
- M  in  MW  signed product from the multiplier stage.
- DAB  in  PW  concatenated D[11:0]:A[17:0]:B[17:0].
- C  in  PW  C operand (already registered upstream).
- PCIN  in  PW  cascade input from the neighbouring slice.
- CARRYIN  in  1  external carry-in.
- P  out  PW  result.
- PCOUT  out  PW  cascade out; always identical to P.
- CARRYOUT  out  1  carry/borrow from the post-adder.
- OVF  out  1  saturation flag; tied 0 without the optional feature.

Behaviour:
- Reset values: opmode_r = 0, p_r = 0, cout_r = 0, ovf_r = 0. P, PCOUT, CARRYOUT and OVF all read 0 while RST is high and after release until the first enabled edge. RST has priority over every CE.
- CE low: the corresponding register holds its value. It does not clear.
- Effective opmode: opm = OPMODEREG ? opmode_r : OPMODE.
- X mux, opm[1:0]:
  - 00: 0
  - 01: M sign-extended to PW
  - 10: p_r
  - 11: DAB
- Z mux, opm[3:2]:
  - 00: 0
  - 01: PCIN
  - 10: p_r
  - 11: C
- Carry-in: cin = opm[4] ? 1 : CARRYIN.
- Arithmetic uses PW+1 bit unsigned math:
  - SUB = 0: sum = Z + X + cin.
  - SUB = 1: sum = Z - (X + cin).
  - Result = sum[PW-1:0]; carry = sum[PW]. With SUB = 1, carry = 1 means borrow.
- Feedback (X or Z = 10) always uses p_r, whatever PREG is set to. This avoids combinational loops.
- p_r loads the result on CLK rising edge when CEP = 1.
- P = PREG ? p_r : result.
- CARRYOUT = CARRYOUTREG ? cout_r : carry.
- Latency from M/C/DAB/PCIN to P: 1 cycle with PREG = 1, 0 with PREG = 0. Add 1 cycle of OPMODE latency when OPMODEREG = 1.
- Accumulate mode (X = 01, Z = 10, CEP = 1): P grows by M every cycle. It wraps modulo 2^48 without the optional feature.
- OPMODE change mid-accumulation takes effect on the next edge (OPMODEREG = 0) or one edge later (OPMODEREG = 1). No flush.
- RST asserted mid-accumulation clears p_r immediately (asynchronous). The accumulation restarts from 0 on the first enabled edge after release.

Optional Feature:
- Macro: DSP_POSTADD_SAT_EN.
- Defined:
  - Signed overflow of the PW-bit result (sign of result ≠ expected sign from Z, X, SUB) clamps the result to 0x7FFF_FFFF_FFFF (positive) or 0x8000_0000_0000 (negative).
  - ovf_r is set on the same CEP edge that registers the clamped value. OVF = ovf_r, or the combinational flag when PREG = 0.
  - CARRYOUT is unaffected.
- Undefined: modulo-2^48 wrap; OVF tied 0; no saturation logic present.

Decomposition:
- Shared package dsp_pkg holds:
  - width constants MW = 36, PW = 48;
  - OPMODE field bit positions;
  - X select localparams X_ZERO, X_M, X_P, X_DAB;
  - Z select localparams Z_ZERO, Z_PCIN, Z_P, Z_C;
  - saturation limit constants.
- Sub-module dsp_ce_reg: N-bit register with async active-high RST, CE hold, and a bypass parameter. It is instantiated for OPMODE, CARRYOUT and OVF. p_r stays inline because of its feedback tap.

Test Plan:
- Reset: drive inputs nonzero, then assert RST mid-cycle → P, PCOUT, CARRYOUT, OVF = 0 immediately. They stay 0 after release until a CEP edge.
- Accumulate: OPMODE = 6'b001001, M = 5, CEP = 1 for 4 cycles → P = 5, 10, 15, 20. Drop CEP → P holds at 20.
- Subtract with borrow: Z = C = 3, X = DAB = 5, SUB = 1, CIN sel = 0, CARRYIN = 0 → P = 0xFFFF_FFFF_FFFE, CARRYOUT = 1.
- Wrap/carry: C = 0xFFFF_FFFF_FFFF, X = 0, CIN sel = 1 → P = 0, CARRYOUT = 1, OVF = 0.
- OPMODEREG = 1: change OPMODE from add to subtract at cycle n with CEOPMODE = 1 → P reflects subtract at the edge n+2, not n+1. With CEOPMODE = 0 the old opmode persists.
- DSP_POSTADD_SAT_EN: C = 0x7FFF_FFFF_FFFF, X = M = 1 → P = 0x7FFF_FFFF_FFFF, OVF = 1. Without the macro → P = 0x8000_0000_0000, OVF = 0.
